control_unit_gen2: RTL and testbench

Parametrised second-generation control unit for the RISC-SPM processor: a Moore/Mealy FSM that fetches, decodes and sequences instructions, driving datapath register loads, bus multiplexers and memory strobes. Generalises the register-file size and word width, adds OR/XOR/BRNZ/HALT opcodes, gives every select output a deterministic idle code, and adds a memory ready/stall handshake plus sticky halt and illegal-opcode status. It sits between the instruction register and the datapath/memory interface.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/control_unit_gen2_onehot_dec.sv | 15 +
 rtl/control_unit_gen2.sv | 179 +++++++++++++++++
 tb/tb_control_unit_gen2.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RISC-SPM gen2 control unit: states, opcodes and
// bus-select codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_NOT  = 4;
    localparam int OP_RD   = 5;
    localparam int OP_WR   = 6;
    localparam int OP_BR   = 7;
    localparam int OP_BRZ  = 8;
    localparam int OP_OR   = 9;
    localparam int OP_XOR  = 10;
    localparam int OP_BRNZ = 11;
    localparam int OP_HALT = 15;

    localparam logic [1:0] BUS2_ALU  = 2'd0;
    localparam logic [1:0] BUS2_BUS1 = 2'd1;
    localparam logic [1:0] BUS2_MEM  = 2'd2;
    localparam logic [1:0] BUS2_IDLE = 2'd3;

endpackage

// File: rtl/control_unit_gen2_onehot_dec.sv
// Register index to one-hot load-enable decoder.
module onehot_dec #(
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0]      idx,
    input  logic                  en,
    output logic [2**IDX_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/control_unit_gen2.sv
// Fetch/decode/sequence FSM for RISC-SPM gen2; Mealy outputs on zero and
// mem_ready, sticky illegal-opcode flag.
module control_unit_gen2
    import ctrl_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int OP_W   = 4,
    parameter int REG_AW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_W-1:0]    instruction,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic [2**REG_AW-1:0] load_reg,
    output logic                 load_pc,
    output logic                 inc_pc,
    output logic                 load_ir,
    output logic                 load_addr,
    output logic                 load_y,
    output logic                 load_z,
    output logic [REG_AW:0]      sel_bus1,
    output logic [1:0]           sel_bus2,
    output logic                 mem_req,
    output logic                 write,
    output logic                 halted,
    output logic                 illegal
);

    localparam int NUM_REGS = 2**REG_AW;
    localparam logic [REG_AW:0] SEL_PC   = (REG_AW+1)'(NUM_REGS);
    localparam logic [REG_AW:0] SEL_IDLE = '0;

    state_t            state, next_state;
    logic              reg_en;
    logic              set_illegal;
    logic [REG_AW-1:0] src, dest;
    int                op;

    assign op   = int'(instruction[WORD_W-1 -: OP_W]);
    assign src  = instruction[2*REG_AW-1:REG_AW];
    assign dest = instruction[REG_AW-1:0];

    always_comb begin
        // NOTE: every output and next_state gets a default before the case,
        // so no path through this block can leave a value unassigned (no latches).
        next_state  = state;
        reg_en      = 1'b0;
        set_illegal = 1'b0;
        load_pc     = 1'b0;
        inc_pc      = 1'b0;
        load_ir     = 1'b0;
        load_addr   = 1'b0;
        load_y      = 1'b0;
        load_z      = 1'b0;
        sel_bus1    = SEL_IDLE;
        sel_bus2    = BUS2_IDLE;
        mem_req     = 1'b0;
        write       = 1'b0;

        case (state)
            S_IDLE: next_state = S_FET1;
            S_FET1: begin
                sel_bus1   = SEL_PC;
                sel_bus2   = BUS2_BUS1;
                load_addr  = 1'b1;
                next_state = S_FET2;
            end
            S_FET2: begin
                mem_req  = 1'b1;
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_ir    = 1'b1;
                    inc_pc     = 1'b1;
                    next_state = S_DEC;
                end
            end
            S_DEC: begin
                case (op)
                    OP_NOP: next_state = S_FET1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        sel_bus1   = {1'b0, src};
                        sel_bus2   = BUS2_BUS1;
                        load_y     = 1'b1;
                        next_state = S_EX1;
                    end
                    OP_NOT: begin
                        sel_bus1   = {1'b0, src};
                        sel_bus2   = BUS2_ALU;
                        load_z     = 1'b1;
                        reg_en     = 1'b1;
                        next_state = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ, OP_BRNZ: begin
                        // Conditional branches that are not taken skip the address word.
                        if ((op == OP_BRZ && !zero) || (op == OP_BRNZ && zero)) begin
                            inc_pc     = 1'b1;
                            next_state = S_FET1;
                        end else begin
                            sel_bus1   = SEL_PC;
                            sel_bus2   = BUS2_BUS1;
                            load_addr  = 1'b1;
                            next_state = (op == OP_RD) ? S_RD1 :
                                         (op == OP_WR) ? S_WR1 : S_BR1;
                        end
                    end
                    OP_HALT: next_state = S_HALT;
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = S_HALT;
                    end
                endcase
            end
            S_EX1: begin
                sel_bus1   = {1'b0, dest};
                sel_bus2   = BUS2_ALU;
                load_z     = 1'b1;
                reg_en     = 1'b1;
                next_state = S_FET1;
            end
            S_RD1, S_WR1: begin
                mem_req  = 1'b1;
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_addr  = 1'b1;
                    inc_pc     = 1'b1;
                    next_state = (state == S_RD1) ? S_RD2 : S_WR2;
                end
            end
            S_RD2: begin
                mem_req  = 1'b1;
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    reg_en     = 1'b1;
                    next_state = S_FET1;
                end
            end
            S_WR2: begin
                mem_req  = 1'b1;
                write    = 1'b1;
                sel_bus1 = {1'b0, src};
                sel_bus2 = BUS2_BUS1;
                if (mem_ready) next_state = S_FET1;
            end
            S_BR1, S_BR2: begin
                mem_req  = 1'b1;
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_addr  = (state == S_BR1);
                    load_pc    = (state == S_BR2);
                    next_state = (state == S_BR1) ? S_BR2 : S_FET1;
                end
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    onehot_dec #(.IDX_W(REG_AW)) u_load_dec (
        .idx    (dest),
        .en     (reg_en),
        .onehot (load_reg)
    );

    assign halted = (state == S_HALT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit_gen2.sv
// Directed, table-driven bench for control_unit_gen2 plus a REG_AW=3 instance.
module tb_control_unit_gen2;

    typedef struct packed {
        logic [3:0] load_reg;
        logic [5:0] strobes;   // load_pc, inc_pc, load_ir, load_addr, load_y, load_z
        logic [2:0] sel_bus1;
        logic [1:0] sel_bus2;
        logic [3:0] flags;     // mem_req, write, halted, illegal
    } outs_t;

    typedef struct {
        string      name;
        logic [7:0] instr;
        logic       zero;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       zero, mem_ready;
    logic [3:0] load_reg;
    logic       load_pc, inc_pc, load_ir, load_addr, load_y, load_z;
    logic [2:0] sel_bus1;
    logic [1:0] sel_bus2;
    logic       mem_req, write, halted, illegal;

    logic [9:0] instruction_b = 10'h12E;  // NOT R5 -> R6
    logic       zero_b = 1'b0, mem_ready_b = 1'b1;
    logic [7:0] load_reg_b;
    logic       load_pc_b, inc_pc_b, load_ir_b, load_addr_b, load_y_b, load_z_b;
    logic [3:0] sel_bus1_b;
    logic [1:0] sel_bus2_b;
    logic       mem_req_b, write_b, halted_b, illegal_b;

    int passed = 0;
    int total  = 0;
    vec_t vq[$];
    outs_t act;

    always #5 clk = ~clk;

    control_unit_gen2 dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .load_reg(load_reg), .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir),
        .load_addr(load_addr), .load_y(load_y), .load_z(load_z), .sel_bus1(sel_bus1),
        .sel_bus2(sel_bus2), .mem_req(mem_req), .write(write), .halted(halted), .illegal(illegal)
    );

    control_unit_gen2 #(.WORD_W(10), .OP_W(4), .REG_AW(3)) dut_b (
        .clk(clk), .rst(rst), .instruction(instruction_b), .zero(zero_b), .mem_ready(mem_ready_b),
        .load_reg(load_reg_b), .load_pc(load_pc_b), .inc_pc(inc_pc_b), .load_ir(load_ir_b),
        .load_addr(load_addr_b), .load_y(load_y_b), .load_z(load_z_b), .sel_bus1(sel_bus1_b),
        .sel_bus2(sel_bus2_b), .mem_req(mem_req_b), .write(write_b), .halted(halted_b),
        .illegal(illegal_b)
    );

    assign act = {load_reg, load_pc, inc_pc, load_ir, load_addr, load_y, load_z,
                  sel_bus1, sel_bus2, mem_req, write, halted, illegal};

    function automatic outs_t o(input logic [3:0] lr, input logic [5:0] st,
                                input logic [2:0] s1, input logic [1:0] s2,
                                input logic [3:0] fl);
        return {lr, st, s1, s2, fl};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic add(input string name, input logic [7:0] instr, input logic z,
                       input logic r, input outs_t exp);
        vec_t v;
        v.name = name; v.instr = instr; v.zero = z; v.rdy = r; v.exp = exp;
        vq.push_back(v);
    endtask

    outs_t o_idle, o_fet1, o_fet2, o_wait, o_addr, o_halt, o_illegal;

    initial begin
        o_idle    = o(4'b0, 6'b000000, 3'd0, 2'd3, 4'b0000);
        o_fet1    = o(4'b0, 6'b000100, 3'd4, 2'd1, 4'b0000);
        o_fet2    = o(4'b0, 6'b011000, 3'd0, 2'd2, 4'b1000);
        o_wait    = o(4'b0, 6'b000000, 3'd0, 2'd2, 4'b1000);
        o_addr    = o_fet1;
        o_halt    = o(4'b0, 6'b000000, 3'd0, 2'd3, 4'b0010);
        o_illegal = o(4'b0, 6'b000000, 3'd0, 2'd3, 4'b0011);

        add("idle",         8'h16, 0, 1, o_idle);
        add("add_fet1",     8'h16, 0, 1, o_fet1);
        add("add_fet2",     8'h16, 0, 1, o_fet2);
        add("add_dec",      8'h16, 0, 1, o(4'b0000, 6'b000010, 3'd1, 2'd1, 4'b0000));
        add("add_ex1",      8'h16, 0, 1, o(4'b0100, 6'b000001, 3'd2, 2'd0, 4'b0000));
        add("rd_fet1",      8'h53, 0, 1, o_fet1);
        add("rd_fet2_wait", 8'h53, 0, 0, o_wait);
        add("rd_fet2",      8'h53, 0, 1, o_fet2);
        add("rd_dec",       8'h53, 0, 1, o_addr);
        add("rd_rd1",       8'h53, 0, 1, o(4'b0000, 6'b010100, 3'd0, 2'd2, 4'b1000));
        add("rd_rd2_wait1", 8'h53, 0, 0, o_wait);
        add("rd_rd2_wait2", 8'h53, 0, 0, o_wait);
        add("rd_rd2",       8'h53, 0, 1, o(4'b1000, 6'b000000, 3'd0, 2'd2, 4'b1000));
        add("wr_fet1",      8'h69, 0, 1, o_fet1);
        add("wr_fet2",      8'h69, 0, 1, o_fet2);
        add("wr_dec",       8'h69, 0, 1, o_addr);
        add("wr_wr1",       8'h69, 0, 1, o(4'b0000, 6'b010100, 3'd0, 2'd2, 4'b1000));
        add("wr_wr2_wait",  8'h69, 0, 0, o(4'b0000, 6'b000000, 3'd2, 2'd1, 4'b1100));
        add("wr_wr2",       8'h69, 0, 1, o(4'b0000, 6'b000000, 3'd2, 2'd1, 4'b1100));
        add("bnz_nt_fet1",  8'hB0, 1, 1, o_fet1);
        add("bnz_nt_fet2",  8'hB0, 1, 1, o_fet2);
        add("bnz_nt_dec",   8'hB0, 1, 1, o(4'b0000, 6'b010000, 3'd0, 2'd3, 4'b0000));
        add("bnz_t_fet1",   8'hB0, 0, 1, o_fet1);
        add("bnz_t_fet2",   8'hB0, 0, 1, o_fet2);
        add("bnz_t_dec",    8'hB0, 0, 1, o_addr);
        add("bnz_t_br1",    8'hB0, 1, 1, o(4'b0000, 6'b000100, 3'd0, 2'd2, 4'b1000));
        add("bnz_t_br2_w",  8'hB0, 1, 0, o_wait);
        add("bnz_t_br2",    8'hB0, 1, 1, o(4'b0000, 6'b100000, 3'd0, 2'd2, 4'b1000));
        add("not_fet1",     8'h49, 0, 1, o_fet1);
        add("not_fet2",     8'h49, 0, 1, o_fet2);
        add("not_dec",      8'h49, 0, 1, o(4'b0010, 6'b000001, 3'd2, 2'd0, 4'b0000));
        add("brz_fet1",     8'h80, 1, 1, o_fet1);
        add("brz_fet2",     8'h80, 1, 1, o_fet2);
        add("brz_dec",      8'h80, 1, 1, o_addr);
        add("brz_br1",      8'h80, 0, 1, o(4'b0000, 6'b000100, 3'd0, 2'd2, 4'b1000));
        add("brz_br2",      8'h80, 0, 1, o(4'b0000, 6'b100000, 3'd0, 2'd2, 4'b1000));
        add("nop_fet1",     8'h00, 0, 1, o_fet1);
        add("nop_fet2",     8'h00, 0, 1, o_fet2);
        add("nop_dec",      8'h00, 0, 1, o_idle);
        add("xor_fet1",     8'hA7, 0, 1, o_fet1);
        add("xor_fet2",     8'hA7, 0, 1, o_fet2);
        add("xor_dec",      8'hA7, 0, 1, o(4'b0000, 6'b000010, 3'd1, 2'd1, 4'b0000));
        add("xor_ex1",      8'hA7, 0, 1, o(4'b1000, 6'b000001, 3'd3, 2'd0, 4'b0000));
        add("halt_fet1",    8'hF0, 0, 1, o_fet1);
        add("halt_fet2",    8'hF0, 0, 1, o_fet2);
        add("halt_dec",     8'hF0, 0, 1, o_idle);
        add("halt_1",       8'hF0, 0, 1, o_halt);
        add("halt_2",       8'hF0, 0, 1, o_halt);

        rst = 1'b0; instruction = 8'h16; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", act, o_idle);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            instruction = vq[i].instr;
            zero        = vq[i].zero;
            mem_ready   = vq[i].rdy;
            @(negedge clk);
            check(vq[i].name, act, vq[i].exp);
            if (i == 1) begin
                check("b_fet1_sel_pc", {28'd0, sel_bus1_b}, 32'd8);
                check("b_fet1_load_addr", {31'd0, load_addr_b}, 32'd1);
            end
            if (i == 3) begin
                check("b_not_sel_bus1", {28'd0, sel_bus1_b}, 32'd5);
                check("b_not_load_reg", {24'd0, load_reg_b}, 32'h40);
                check("b_not_load_z", {31'd0, load_z_b}, 32'd1);
            end
            @(posedge clk);
            #1;
        end

        // Reset from HALT, then reset while a fetch is stalled.
        #2 rst = 1'b0;
        #1 check("rst_from_halt", act, o_idle);
        @(posedge clk);
        #1 rst = 1'b1; instruction = 8'hD0; mem_ready = 1'b0;
        @(negedge clk); check("rst_idle1", act, o_idle);
        @(posedge clk); #1;
        @(negedge clk); check("rst_fet1", act, o_fet1);
        @(posedge clk); #1;
        @(negedge clk); check("rst_fet2_wait", act, o_wait);
        #1 rst = 1'b0;
        #1 check("rst_mid_fet2", act, o_idle);
        @(posedge clk);
        #1 rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk); check("rst_idle2", act, o_idle);
        @(posedge clk); #1;
        @(negedge clk); check("rst_fet1_again", act, o_fet1);

        // Opcode 13: HALT with sticky illegal until reset.
        @(posedge clk); #1;
        @(negedge clk); check("ill_fet2", act, o_fet2);
        @(posedge clk); #1;
        @(negedge clk); check("ill_dec", act, o_idle);
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("ill_halt_%0d", k), act, o_illegal);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        #1 check("ill_cleared", act, o_idle);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
